// File: rtl/seven_seg_mux_if.sv
// Display-side bundle for seven_seg_mux: data/flags/load toward the driver, pins back out.
interface seven_seg_mux_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] hex_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                load;
  logic [7:0]          segments_n;
  logic [DIGITS-1:0]   digit_n;
  logic                frame_start;

  modport master (
    output hex_in, dp_in, blank_in, load,
    input  segments_n, digit_n, frame_start
  );

  modport slave (
    input  hex_in, dp_in, blank_in, load,
    output segments_n, digit_n, frame_start
  );
endinterface

// File: rtl/seven_seg_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous update.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic           clk,
  input  logic           reset,
  seven_seg_mux_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // PRIME keeps frame_start quiet until the first complete frame has elapsed.
  typedef enum logic {PRIME, RUN} phase_t;

  phase_t              phase;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                cnt_last;
  logic                idx_last;

  logic [4*DIGITS-1:0] sh_hex;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [4*DIGITS-1:0] act_hex;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   act_blank;

  logic [DIGITS-1:0]   blank_eff;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          hex_cur;
  logic                dp_cur;
  logic                blank_cur;

  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   dig_q;
  logic                fs_q;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign cnt_last = (cnt == CW'(SCAN_DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));

`ifdef SEVEN_SEG_LZB_EN
  logic [DIGITS-1:0] lzb;
  logic              lead;

  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin
    lzb  = '0;
    lead = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (act_hex[4*i +: 4] == 4'h0) && !act_dp[i]) begin
        lzb[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  assign blank_eff = act_blank | lzb;
`else
  assign blank_eff = act_blank;
`endif

  always_comb begin
    sel       = '0;
    hex_cur   = 4'h0;
    dp_cur    = 1'b0;
    blank_cur = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      sel[i] = (idx == IW'(i));
      if (sel[i]) begin
        hex_cur   = act_hex[4*i +: 4];
        dp_cur    = act_dp[i];
        blank_cur = blank_eff[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= PRIME;
      cnt       <= '0;
      idx       <= '0;
      sh_hex    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      act_hex   <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      seg_q     <= '1;
      dig_q     <= '1;
      fs_q      <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_hex   <= bus.hex_in;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
      end

      // On the frame edge active samples the pre-edge shadow, so a coincident load waits a frame.
      if (cnt_last) begin
        cnt <= '0;
        if (idx_last) begin
          idx       <= '0;
          act_hex   <= sh_hex;
          act_dp    <= sh_dp;
          act_blank <= sh_blank;
          phase     <= RUN;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Segments carry the digit's data during the guard so new data reaches the pins early;
      // only the anode enable is withheld.
      dig_q <= ((cnt == '0) || blank_cur) ? '1 : ~sel;
      seg_q <= blank_cur ? 8'hFF : ~{dp_cur, seg7(hex_cur)};
      fs_q  <= (phase == RUN) && (cnt == '0) && (idx == '0);
    end
  end

  assign bus.segments_n  = seg_q;
  assign bus.digit_n     = dig_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux (DIGITS=4, SCAN_DIV=4): stimulus queues expected frames,
// a monitor checks each queued frame when frame_start marks its first cycle.
module tb_seven_seg_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct packed {
    logic [3:0][3:0] dig;
    logic [3:0][7:0] seg;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  frame_t sb[$];

  always #5 clk = ~clk;

  seven_seg_mux_if #(.DIGITS(DIGITS)) bus_if ();

  seven_seg_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] d, input logic [31:0] s);
    frame_t f;
    f.dig = d;
    f.seg = s;
    return f;
  endfunction

  task automatic wait_fs();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (bus_if.frame_start === 1'b1) seen = 1'b1;
    end
    check("frame_start_seen", 8'(seen), 8'h01);
  endtask

  task automatic load_and_expect(input logic [15:0] h, input logic [3:0] d,
                                 input logic [3:0] b, input frame_t e);
    wait_fs();
    repeat (2) @(negedge clk);
    bus_if.hex_in   = h;
    bus_if.dp_in    = d;
    bus_if.blank_in = b;
    bus_if.load     = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: one queued frame per frame_start; guard cycle = first of each 4-cycle slot.
  initial begin
    frame_t f;
    int s;
    int ph;
    forever begin
      @(negedge clk);
      if (bus_if.frame_start === 1'b1 && sb.size() > 0) begin
        f = sb.pop_front();
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge clk);
          s  = c / SCAN_DIV;
          ph = c % SCAN_DIV;
          check("frame_start", 8'(bus_if.frame_start), (c == 0) ? 8'h01 : 8'h00);
          if (ph == 0) begin
            check("guard_digit_n", 8'(bus_if.digit_n), 8'h0F);
            if (f.dig[s] == 4'hF) check("blank_seg_guard", bus_if.segments_n, 8'hFF);
          end else begin
            check($sformatf("slot%0d_digit_n", s), 8'(bus_if.digit_n), 8'(f.dig[s]));
            check($sformatf("slot%0d_segments_n", s), bus_if.segments_n, f.seg[s]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    reset           = 1'b1;
    bus_if.hex_in   = '0;
    bus_if.dp_in    = '0;
    bus_if.blank_in = '0;
    bus_if.load     = 1'b0;
    #20 reset = 1'b0;

    // 1: asynchronous reset mid-scan, then first frame_start timing and dark display
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_segments_n", bus_if.segments_n, 8'hFF);
    check("rst_digit_n", 8'(bus_if.digit_n), 8'h0F);
    check("rst_frame_start", 8'(bus_if.frame_start), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(16'hFFFF, 32'hFFFF_FFFF));
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus_if.frame_start === 1'b1) break;
    end
    check("first_fs_delay", 8'(n), 8'(FRAME));

    // 2: basic scan of 12AF
    load_and_expect(16'h12AF, 4'b0000, 4'b0000, mk(16'h7BDE, 32'hF9A4_888E));

    // 3: dp on digit 1, blank on digit 3
    load_and_expect(16'h12AF, 4'b0010, 4'b1000, mk(16'hFBDE, 32'hFFA4_088E));

    // 4: tear-free update, then a load on the frame-edge cycle
    load_and_expect(16'h1111, 4'b0000, 4'b0000, mk(16'h7BDE, 32'hF9F9_F9F9));
    wait_fs();
    repeat (9) @(negedge clk);
    bus_if.hex_in = 16'h2222;
    bus_if.load   = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    sb.push_back(mk(16'h7BDE, 32'hA4A4_A4A4));
    wait_fs();
    repeat (14) @(negedge clk);
    bus_if.hex_in = 16'h3333;
    bus_if.load   = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    sb.push_back(mk(16'h7BDE, 32'hA4A4_A4A4));
    sb.push_back(mk(16'h7BDE, 32'hB0B0_B0B0));
    wait_fs();

    // 5: leading zeros, with and without a decimal point in the middle
`ifdef SEVEN_SEG_LZB_EN
    load_and_expect(16'h0005, 4'b0000, 4'b0000, mk(16'hFFFE, 32'hFFFF_FF92));
    load_and_expect(16'h0005, 4'b0100, 4'b0000, mk(16'hFBDE, 32'hFF40_C092));
`else
    load_and_expect(16'h0005, 4'b0000, 4'b0000, mk(16'h7BDE, 32'hC0C0_C092));
    load_and_expect(16'h0005, 4'b0100, 4'b0000, mk(16'h7BDE, 32'hC040_C092));
`endif

    // 6: reset while data is lit, dark afterwards until a new load reaches a frame edge
    wait_fs();
    wait_fs();
    repeat (5) @(negedge clk);
    check("lit_before_rst_digit_n", 8'(bus_if.digit_n), 8'h0D);
    check("lit_before_rst_segments_n", bus_if.segments_n, 8'hC0);
    #2 reset = 1'b1;
    #1;
    check("rst2_segments_n", bus_if.segments_n, 8'hFF);
    check("rst2_digit_n", 8'(bus_if.digit_n), 8'h0F);
    check("rst2_frame_start", 8'(bus_if.frame_start), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(16'hFFFF, 32'hFFFF_FFFF));
    load_and_expect(16'hC0DE, 4'b0000, 4'b0000, mk(16'h7BDE, 32'hC6C0_A186));
    wait_fs();
    repeat (FRAME + 1) @(negedge clk);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
